memctl: RTL and testbench

KS10 main-memory controller; sits directly downstream of the CPU datapath. Accepts word read, write and read-modify-write (RMW) requests, drives a synchronous external SSRAM with programmable wait states, and returns read data for the CPU `d` input. Requests come from the ALU `t` output and the CPU address path. Addresses at or above the installed memory size take the non-existent-memory (NXM) path after a timeout.

---
 rtl/memctl_if.sv | 35 +++
 rtl/memctl.sv | 109 ++++++++++
 tb/tb_memctl.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/memctl_if.sv
// Request/response and SSRAM pin bundle for the KS10 main-memory controller.
// The CPU side uses the master modport and the controller uses the slave modport.
interface memctl_if #(
    parameter int ADDR_WIDTH = 20
);
    logic                  req;
    logic                  rd;
    logic                  wr;
    logic [ADDR_WIDTH-1:0] addr;
    logic [0:35]           wdata;
    logic [0:35]           rdata;
    logic                  ack;
    logic                  nxm;
    logic                  busy;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [0:35]           mem_din;
    logic [0:35]           mem_dout;
    logic                  mem_ce;
    logic                  mem_we;

    modport master (
        output req, rd, wr, addr, wdata,
        input  rdata, ack, nxm, busy
    );

    modport slave (
        input  req, rd, wr, addr, wdata, mem_dout,
        output rdata, ack, nxm, busy, mem_addr, mem_din, mem_ce, mem_we
    );

    modport ram (
        input  mem_addr, mem_din, mem_ce, mem_we,
        output mem_dout
    );
endinterface

// File: rtl/memctl.sv
// KS10 main-memory controller: word read/write/RMW to a synchronous SSRAM with
// programmable wait states, and an NXM timeout for addresses beyond installed memory.
module memctl #(
    parameter int ADDR_WIDTH  = 20,
    parameter int MEM_SIZE    = 524288,
    parameter int WAIT_STATES = 1,
    parameter int NXM_TIMEOUT = 8
) (
    input  logic     clk,
    input  logic     rst,
    memctl_if.slave  bus
);
    typedef enum logic [2:0] {IDLE, ACCESS, ACK, NXM_WAIT, RMW_WAIT} state_t;
    typedef enum logic [1:0] {CMD_READ, CMD_WRITE, CMD_RMW} cmd_t;

    localparam int                  NXM_LAST  = NXM_TIMEOUT - 1;
    localparam logic [ADDR_WIDTH:0] MEM_LIMIT = MEM_SIZE[ADDR_WIDTH:0];
    localparam logic [7:0]          WAIT_INIT = WAIT_STATES[7:0];
    localparam logic [7:0]          NXM_INIT  = NXM_LAST[7:0];

    state_t     state;
    cmd_t       cmd;
    logic       rmw_lock;
    logic [7:0] cnt;

    // NOTE: all state and registered outputs use <= so every branch sees pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            cmd          <= CMD_READ;
            rmw_lock     <= 1'b0;
            cnt          <= '0;
            bus.rdata    <= '0;
            bus.ack      <= 1'b0;
            bus.nxm      <= 1'b0;
            bus.busy     <= 1'b0;
            bus.mem_addr <= '0;
            bus.mem_din  <= '0;
            bus.mem_ce   <= 1'b0;
            bus.mem_we   <= 1'b0;
        end else begin
            bus.ack <= 1'b0;
            bus.nxm <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.req && (bus.rd || bus.wr)) begin
                        cmd      <= bus.wr ? (bus.rd ? CMD_RMW : CMD_WRITE) : CMD_READ;
                        bus.busy <= 1'b1;
                        if ({1'b0, bus.addr} >= MEM_LIMIT) begin
                            state <= NXM_WAIT;
                            cnt   <= NXM_INIT;
                        end else begin
                            state        <= ACCESS;
                            cnt          <= WAIT_INIT;
                            bus.mem_ce   <= 1'b1;
                            bus.mem_we   <= bus.wr && !bus.rd;
                            bus.mem_addr <= bus.addr;
                            bus.mem_din  <= bus.wdata;
                        end
                    end
                end
                ACCESS: begin
                    if (cnt == 8'd0) begin
                        state      <= ACK;
                        bus.ack    <= 1'b1;
                        bus.mem_ce <= 1'b0;
                        bus.mem_we <= 1'b0;
                        if (!bus.mem_we) bus.rdata <= bus.mem_dout;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                ACK: begin
                    // Only the read half of an RMW parks in RMW_WAIT; its write half finishes normally.
                    if (cmd == CMD_RMW && !rmw_lock) begin
                        state    <= RMW_WAIT;
                        rmw_lock <= 1'b1;
                    end else begin
                        state    <= IDLE;
                        bus.busy <= 1'b0;
                        rmw_lock <= 1'b0;
                    end
                end
                NXM_WAIT: begin
                    if (bus.nxm) begin
                        state    <= IDLE;
                        bus.busy <= 1'b0;
                    end else if (cnt == 8'd0) begin
                        bus.nxm <= 1'b1;
                        if (cmd != CMD_WRITE) bus.rdata <= '0;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                RMW_WAIT: begin
                    // The write half reuses the locked address; only the new wdata is taken.
                    if (bus.req) begin
                        state       <= ACCESS;
                        cnt         <= WAIT_INIT;
                        bus.mem_ce  <= 1'b1;
                        bus.mem_we  <= 1'b1;
                        bus.mem_din <= bus.wdata;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_memctl.sv
// Self-checking bench for memctl: a transaction-level timeline model predicts every
// output per cycle, and directed tests add hand-computed literal expectations.
module tb_memctl;
    localparam int AW  = 20;
    localparam int MSZ = 524288;
    localparam int W   = 1;
    localparam int T   = 8;
    localparam int N   = 512;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    memctl_if #(.ADDR_WIDTH(AW)) ifc ();

    memctl #(
        .ADDR_WIDTH (AW),
        .MEM_SIZE   (MSZ),
        .WAIT_STATES(W),
        .NXM_TIMEOUT(T)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(ifc)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0o, required %0o (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Flow-through SSRAM: reads follow mem_addr, writes land on a clock edge with ce&we.
    logic [0:35] ssram [0:4095];
    assign ifc.mem_dout = ssram[ifc.mem_addr[11:0]];
    initial begin
        for (int i = 0; i < 4096; i++) ssram[i] = '0;
        ssram[12'o1000] = 36'o123456701234;
        ssram[7]        = 36'o1;
        ssram[9]        = 36'o5555;
        forever begin
            @(posedge clk);
            if (ifc.mem_ce && ifc.mem_we) ssram[ifc.mem_addr[11:0]] <= ifc.mem_din;
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Expected timeline, indexed by cycle number (period after the cyc-th rising edge).
    logic          x_ce   [N];
    logic          x_we   [N];
    logic          x_ack  [N];
    logic          x_nxm  [N];
    logic          x_busy [N];
    logic [AW-1:0] x_maddr[N];
    logic [0:35]   x_mdin [N];
    logic [0:35]   x_rdata[N];
    logic [0:35]   model_mem [0:4095];
    int            free = 0;
    bit            rmw_lock = 1'b0;
    logic [AW-1:0] rmw_addr = '0;
    logic [AW-1:0] last_wr_addr = '0;
    logic [0:35]   last_wr_old = '0;

    function automatic void fill_busy(input int from, input logic v);
        for (int i = from; i < N; i++) x_busy[i] = v;
    endfunction

    function automatic void fill_rdata(input int from, input logic [0:35] v);
        for (int i = from; i < N; i++) x_rdata[i] = v;
    endfunction

    function automatic void model_clear(input int from);
        for (int i = from; i < N; i++) begin
            x_ce[i] = 1'b0; x_we[i] = 1'b0; x_ack[i] = 1'b0; x_nxm[i] = 1'b0;
            x_busy[i] = 1'b0; x_maddr[i] = '0; x_mdin[i] = '0; x_rdata[i] = '0;
        end
    endfunction

    function automatic void access(input int e, input bit is_wr, input logic [AW-1:0] a,
                                   input logic [0:35] d);
        fill_busy(e, 1'b1);
        for (int c = e; c <= e + W; c++) begin
            x_ce[c] = 1'b1; x_we[c] = is_wr; x_maddr[c] = a; x_mdin[c] = d;
        end
        x_ack[e + W + 1] = 1'b1;
        if (is_wr) begin
            last_wr_addr = a;
            last_wr_old  = model_mem[a[11:0]];
            model_mem[a[11:0]] = d;
        end else begin
            fill_rdata(e + W + 1, model_mem[a[11:0]]);
        end
    endfunction

    function automatic void predict(input logic rd, input logic wr, input logic [AW-1:0] a,
                                    input logic [0:35] d, input int e);
        if (rmw_lock) begin
            access(e, 1'b1, rmw_addr, d);
            rmw_lock = 1'b0;
            free = e + W + 2;
            fill_busy(free, 1'b0);
        end else if (rd || wr) begin
            if (int'(a) >= MSZ) begin
                fill_busy(e, 1'b1);
                x_nxm[e + T] = 1'b1;
                if (rd) fill_rdata(e + T, '0);
                free = e + T + 1;
                fill_busy(free, 1'b0);
            end else begin
                access(e, wr && !rd, a, d);
                free = e + W + 2;
                if (rd && wr) begin
                    rmw_lock = 1'b1;
                    rmw_addr = a;
                end else begin
                    fill_busy(free, 1'b0);
                end
            end
        end
    endfunction

    bit cmp_en = 1'b0;
    always @(negedge clk) begin
        if (cmp_en && cyc < N) begin
            check("mem_ce", ifc.mem_ce, x_ce[cyc]);
            check("mem_we", ifc.mem_we, x_we[cyc]);
            check("ack", ifc.ack, x_ack[cyc]);
            check("nxm", ifc.nxm, x_nxm[cyc]);
            check("busy", ifc.busy, x_busy[cyc]);
            check("rdata", ifc.rdata, x_rdata[cyc]);
            if (x_ce[cyc]) check("mem_addr", ifc.mem_addr, x_maddr[cyc]);
            if (x_we[cyc]) check("mem_din", ifc.mem_din, x_mdin[cyc]);
        end
    end

    int ce_total = 0;
    int we_total = 0;
    int ack_total = 0;
    int busy_total = 0;
    int nxm_last = -1;
    int ack_q[$];
    always @(negedge clk) begin
        if (ifc.mem_ce) ce_total++;
        if (ifc.mem_we) we_total++;
        if (ifc.busy) busy_total++;
        if (ifc.ack) begin
            ack_total++;
            ack_q.push_back(cyc);
        end
        if (ifc.nxm) nxm_last = cyc;
    end

    task automatic issue(input logic rd, input logic wr, input logic [AW-1:0] a,
                         input logic [0:35] d, output int e);
        @(negedge clk);
        while (cyc < free) @(negedge clk);
        ifc.req = 1'b1; ifc.rd = rd; ifc.wr = wr; ifc.addr = a; ifc.wdata = d;
        @(posedge clk);
        #1;
        e = cyc;
        predict(rd, wr, a, d, e);
    endtask

    task automatic release_req();
        @(negedge clk);
        ifc.req = 1'b0; ifc.rd = 1'b0; ifc.wr = 1'b0;
    endtask

    task automatic wait_idle();
        @(negedge clk);
        while (cyc < free + 1) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

    initial begin
        int e, e1, e2, e3, ce0, we0, ack0, busy0;
        ifc.req = 1'b0; ifc.rd = 1'b0; ifc.wr = 1'b0; ifc.addr = '0; ifc.wdata = '0;
        model_clear(0);
        for (int i = 0; i < 4096; i++) model_mem[i] = '0;
        model_mem[12'o1000] = 36'o123456701234;
        model_mem[7]        = 36'o1;
        model_mem[9]        = 36'o5555;

        repeat (2) @(negedge clk);
        check("reset busy", ifc.busy, 1'b0);
        check("reset ack", ifc.ack, 1'b0);
        check("reset nxm", ifc.nxm, 1'b0);
        check("reset mem_ce", ifc.mem_ce, 1'b0);
        check("reset mem_we", ifc.mem_we, 1'b0);
        check("reset rdata", ifc.rdata, 36'o0);
        rst = 1'b0;
        cmp_en = 1'b1;
        free = cyc;

        // Plain read at 0o1000.
        ce0 = ce_total;
        issue(1'b1, 1'b0, 20'o1000, '0, e);
        release_req();
        wait_idle();
        check("read ce cycles", ce_total - ce0, 2);
        check("read ack cycle", ack_q[$] - e + 1, 3);
        check("read rdata", ifc.rdata, 36'o123456701234);

        // Write then readback of address 5.
        we0 = we_total;
        issue(1'b0, 1'b1, 20'd5, 36'o777777777777, e);
        release_req();
        wait_idle();
        check("write we cycles", we_total - we0, 2);
        check("write ack cycle", ack_q[$] - e + 1, 3);
        check("write keeps rdata", ifc.rdata, 36'o123456701234);
        issue(1'b1, 1'b0, 20'd5, '0, e);
        release_req();
        wait_idle();
        check("readback addr 5", ifc.rdata, 36'o777777777777);

        // NXM read, then a valid read.
        ce0 = ce_total; ack0 = ack_total;
        issue(1'b1, 1'b0, 20'o2000000, '0, e);
        release_req();
        wait_idle();
        check("nxm ce cycles", ce_total - ce0, 0);
        check("nxm cycle", nxm_last - e + 1, 9);
        check("nxm no ack", ack_total - ack0, 0);
        check("nxm rdata", ifc.rdata, 36'o0);
        issue(1'b1, 1'b0, 20'o1000, '0, e);
        release_req();
        wait_idle();
        check("post-nxm read", ifc.rdata, 36'o123456701234);

        // RMW at 7; the second request's addr and rd/wr are ignored.
        ack0 = ack_total;
        issue(1'b1, 1'b1, 20'd7, 36'o0, e);
        release_req();
        while (cyc < e + W + 2) @(negedge clk);
        check("rmw read data", ifc.rdata, 36'o1);
        repeat (2) @(negedge clk);
        check("rmw busy held", ifc.busy, 1'b1);
        issue(1'b1, 1'b0, 20'd9, 36'o2, e);
        release_req();
        wait_idle();
        check("rmw write lands", ssram[7], 36'o2);
        check("rmw addr 9 intact", ssram[9], 36'o5555);
        check("rmw ack count", ack_total - ack0, 2);
        check("rmw idle busy", ifc.busy, 1'b0);

        // Back-to-back reads with req held high.
        issue(1'b1, 1'b0, 20'd5, '0, e1);
        issue(1'b1, 1'b0, 20'd7, '0, e2);
        issue(1'b1, 1'b0, 20'o1000, '0, e3);
        release_req();
        wait_idle();
        check("b2b spacing 1", ack_q[$-1] - ack_q[$-2], 4);
        check("b2b spacing 2", ack_q[$] - ack_q[$-1], 4);
        check("b2b accept spacing", e3 - e1, 8);
        check("b2b rdata", ifc.rdata, 36'o123456701234);

        // A request with no command is ignored.
        busy0 = busy_total; ack0 = ack_total;
        issue(1'b0, 1'b0, 20'd3, 36'o7, e);
        repeat (3) @(negedge clk);
        ifc.req = 1'b0;
        repeat (2) @(negedge clk);
        check("noop busy", busy_total - busy0, 0);
        check("noop ack", ack_total - ack0, 0);

        // Reset during cycle 1 of a write to address 11.
        ack0 = ack_total;
        issue(1'b0, 1'b1, 20'd11, 36'o4444, e);
        check("pre-reset mem_ce", ifc.mem_ce, 1'b1);
        check("pre-reset mem_we", ifc.mem_we, 1'b1);
        #1;
        rst = 1'b1;
        ifc.req = 1'b0; ifc.rd = 1'b0; ifc.wr = 1'b0;
        model_clear(e);
        rmw_lock = 1'b0;
        model_mem[last_wr_addr[11:0]] = last_wr_old;
        #1;
        check("async mem_ce", ifc.mem_ce, 1'b0);
        check("async mem_we", ifc.mem_we, 1'b0);
        check("async busy", ifc.busy, 1'b0);
        check("async rdata", ifc.rdata, 36'o0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        free = cyc;
        repeat (3) @(negedge clk);
        check("reset no write", ssram[11], 36'o0);
        check("reset no ack", ack_total - ack0, 0);
        issue(1'b1, 1'b0, 20'o1000, '0, e);
        release_req();
        wait_idle();
        check("post-reset ack cycle", ack_q[$] - e + 1, 3);
        check("post-reset read", ifc.rdata, 36'o123456701234);

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
